fnd_capture: RTL and testbench

Receive-side counterpart of the 4-digit FND scan driver. Samples the multiplexed `seg_comm`/`seg` lines and recovers the four decimal digits from the segment patterns. Converts them back to the 14-bit binary value shown on the display. Used as a self-check monitor on the display bus and as the decode stage for boards that observe another unit's FND.

---
 rtl/fnd_capture.sv | 161 ++++++++++++++++
 tb/tb_fnd_capture.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fnd_capture.sv
// fnd_capture: receive-side monitor for a 4-digit multiplexed FND bus.
// Filters the scanned segment lines, decodes digits and rebuilds the binary value.
module fnd_capture #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  seg_comm,
    input  logic [7:0]  seg,
    output logic [13:0] count,
    output logic        count_valid,
    output logic        frame_done,
    output logic        decode_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES - 1);

    logic [11:0]      sync1;
    logic [11:0]      sync2;
    logic [11:0]      s_prev;
    logic [7:0]       stable_cnt;
    logic             captured;
    logic             same;
    logic             capture;

    logic [1:0]       pos;
    logic             pos_ok;
    logic [3:0]       dig_val;
    logic             dig_ok;

    logic [3:0][3:0]  dig;
    logic [3:0][3:0]  snap;
    logic [3:0]       seen;
    logic [3:0]       seen_next;

    logic [1:0]       state;
    logic [1:0]       step;
    logic [13:0]      acc;

    assign same    = (sync2 == s_prev);
    assign capture = same && (stable_cnt == SETTLE_MAX) && !captured;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            s_prev     <= '0;
            stable_cnt <= '0;
            captured   <= 1'b0;
        end else begin
            sync1  <= {seg_comm, seg};
            sync2  <= sync1;
            s_prev <= sync2;
            if (!same) begin
                stable_cnt <= '0;
                captured   <= 1'b0;
            end else begin
                if (stable_cnt != SETTLE_MAX)
                    stable_cnt <= stable_cnt + 8'd1;
                if (capture)
                    captured <= 1'b1;
            end
        end
    end

    always_comb begin
        pos    = 2'd0;
        pos_ok = 1'b1;
        case (sync2[11:8])
            4'b1110: pos = 2'd0;
            4'b1101: pos = 2'd1;
            4'b1011: pos = 2'd2;
            4'b0111: pos = 2'd3;
            default: pos_ok = 1'b0;
        endcase
    end

    // dp (bit 7) is deliberately not part of the digit match
    always_comb begin
        dig_val = 4'd0;
        dig_ok  = 1'b1;
        case (sync2[6:0])
            7'h40:   dig_val = 4'd0;
            7'h79:   dig_val = 4'd1;
            7'h24:   dig_val = 4'd2;
            7'h30:   dig_val = 4'd3;
            7'h19:   dig_val = 4'd4;
            7'h12:   dig_val = 4'd5;
            7'h02:   dig_val = 4'd6;
            7'h78:   dig_val = 4'd7;
            7'h00:   dig_val = 4'd8;
            7'h10:   dig_val = 4'd9;
            default: dig_ok  = 1'b0;
        endcase
    end

    // A capture landing on the snapshot edge keeps its seen bit
    always_comb begin
        seen_next = seen;
        if (state == IDLE && seen == 4'hF)
            seen_next = '0;
        if (capture && pos_ok)
            seen_next[pos] = dig_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig        <= '0;
            seen       <= '0;
            decode_err <= 1'b0;
        end else begin
            seen       <= seen_next;
            decode_err <= capture && pos_ok && !dig_ok;
            if (capture && pos_ok && dig_ok)
                dig[pos] <= dig_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            step        <= '0;
            acc         <= '0;
            snap        <= '0;
            count       <= '0;
            count_valid <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (seen == 4'hF) begin
                        snap  <= dig;
                        acc   <= '0;
                        step  <= '0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    acc  <= (acc << 3) + (acc << 1)
                          + {10'd0, snap[2'd3 - step]};
                    step <= step + 2'd1;
                    if (step == 2'd3)
                        state <= DONE;
                end
                DONE: begin
                    count       <= acc;
                    count_valid <= 1'b1;
                    frame_done  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fnd_capture.sv
// tb_fnd_capture: directed table-driven bench for fnd_capture.
// Scans digit patterns onto the bus and checks the recovered value.
module tb_fnd_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  seg_comm;
    logic [7:0]  seg;
    logic [13:0] count;
    logic        count_valid;
    logic        frame_done;
    logic        decode_err;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;
    int err_cnt = 0;
    int fd_log[$];

    typedef struct {
        logic [7:0] p3;
        logic [7:0] p2;
        logic [7:0] p1;
        logic [7:0] p0;
        int         exp_count;
        int         exp_frames;
        int         exp_errs;
    } vec_t;

    vec_t vecs[6];

    fnd_capture #(.SETTLE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_comm    (seg_comm),
        .seg         (seg),
        .count       (count),
        .count_valid (count_valid),
        .frame_done  (frame_done),
        .decode_err  (decode_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) begin
            fd_cnt++;
            fd_log.push_back(int'(count));
        end
        if (decode_err)
            err_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] c, input logic [7:0] v,
                        input int n);
        seg_comm = c;
        seg      = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [7:0] p3, input logic [7:0] p2,
                        input logic [7:0] p1, input logic [7:0] p0,
                        input int dwell);
        hold(4'b0111, p3, dwell);
        hold(4'b1011, p2, dwell);
        hold(4'b1101, p1, dwell);
        hold(4'b1110, p0, dwell);
    endtask

    initial begin
        int f0;
        int e0;
        int base;
        int exp_seq[4];

        vecs[0] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 1234, 1, 0};
        vecs[1] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 0, 1, 0};
        vecs[2] = '{8'h90, 8'h90, 8'h90, 8'h90, 9999, 1, 0};
        vecs[3] = '{8'hC0, 8'hC0, 8'h99, 8'hA4, 42, 1, 0};
        vecs[4] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8765, 1, 0};
        vecs[5] = '{8'hF9, 8'h88, 8'hB0, 8'h99, 8765, 0, 1};

        reset    = 1'b1;
        seg_comm = 4'hF;
        seg      = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_count", int'(count), 0);
        chk("reset_valid", int'(count_valid), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        chk("reset_decode_err", int'(decode_err), 0);
        reset = 1'b0;
        hold(4'hF, 8'hFF, 10);

        for (int i = 0; i < 6; i++) begin
            f0 = fd_cnt;
            e0 = err_cnt;
            scan(vecs[i].p3, vecs[i].p2, vecs[i].p1, vecs[i].p0, 50);
            hold(4'hF, 8'hFF, 20);
            chk($sformatf("vec%0d_count", i), int'(count),
                vecs[i].exp_count);
            chk($sformatf("vec%0d_frames", i), fd_cnt - f0,
                vecs[i].exp_frames);
            chk($sformatf("vec%0d_errs", i), err_cnt - e0,
                vecs[i].exp_errs);
            chk($sformatf("vec%0d_valid", i), int'(count_valid), 1);
        end

        // hundreds position rescanned with a good pattern completes the frame
        f0 = fd_cnt;
        e0 = err_cnt;
        hold(4'b1011, 8'h80, 50);
        hold(4'hF, 8'hFF, 20);
        chk("rescan_count", int'(count), 1834);
        chk("rescan_frames", fd_cnt - f0, 1);
        chk("rescan_errs", err_cnt - e0, 0);

        // 3-cycle F8 glitch at the start of every dwell
        f0 = fd_cnt;
        e0 = err_cnt;
        hold(4'b0111, 8'hF8, 3);
        hold(4'b0111, 8'hF9, 47);
        hold(4'b1011, 8'hF8, 3);
        hold(4'b1011, 8'hA4, 47);
        hold(4'b1101, 8'hF8, 3);
        hold(4'b1101, 8'hB0, 47);
        hold(4'b1110, 8'hF8, 3);
        hold(4'b1110, 8'h99, 47);
        hold(4'hF, 8'hFF, 20);
        chk("glitch_count", int'(count), 1234);
        chk("glitch_frames", fd_cnt - f0, 1);
        chk("glitch_errs", err_cnt - e0, 0);

        f0 = fd_cnt;
        e0 = err_cnt;
        hold(4'b1111, 8'hA4, 30);
        hold(4'b1100, 8'h88, 30);
        hold(4'hF, 8'hFF, 20);
        chk("ignore_frames", fd_cnt - f0, 0);
        chk("ignore_errs", err_cnt - e0, 0);

        // reset lands while the conversion is in flight
        f0 = fd_cnt;
        hold(4'b0111, 8'hF9, 20);
        hold(4'b1011, 8'hA4, 20);
        hold(4'b1101, 8'hB0, 20);
        hold(4'b1110, 8'h80, 9);
        reset = 1'b1;
        #1;
        chk("midconv_count", int'(count), 0);
        chk("midconv_valid", int'(count_valid), 0);
        chk("midconv_frame_done", int'(frame_done), 0);
        chk("midconv_decode_err", int'(decode_err), 0);
        seg_comm = 4'hF;
        seg      = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        hold(4'hF, 8'hFF, 30);
        chk("postreset_frames", fd_cnt - f0, 0);
        chk("postreset_valid", int'(count_valid), 0);

        f0   = fd_cnt;
        base = fd_log.size();
        exp_seq = '{42, 8765, 42, 8765};
        for (int k = 0; k < 2; k++) begin
            scan(8'hC0, 8'hC0, 8'h99, 8'hA4, 12);
            scan(8'h80, 8'hF8, 8'h82, 8'h92, 12);
        end
        hold(4'hF, 8'hFF, 20);
        chk("b2b_frames", fd_cnt - f0, 4);
        for (int k = 0; k < 4; k++) begin
            if (base + k < fd_log.size())
                chk($sformatf("b2b_frame%0d", k), fd_log[base + k],
                    exp_seq[k]);
            else
                chk($sformatf("b2b_frame%0d_missing", k), -1,
                    exp_seq[k]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
